// File: rtl/pipeline_ctrl.sv
// Pipeline latch/PC sequencer: decides load, hold or flush per latch each cycle,
// and tracks outstanding data accesses, sticky halt and stall/flush event counts.
//
// state | meaning
// RUN   | normal issue; hazards resolved combinationally each cycle
// DWAIT | data access outstanding in MEM; front of pipe frozen
// HALT  | halt retired; everything frozen until reset
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic [1:0]       mem_pcSrc,
  input  logic             mem_halt,
  input  logic             idex_dREN,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t state, state_nxt;
  logic   dreq, lu_haz;
  logic   stall_ev, flush_ev;
  logic   pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld;

  assign dreq   = mem_dREN | mem_dWEN;
  assign lu_haz = idex_dREN & (idex_rd != 5'd0) &
                  ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    pc_ld       = 1'b0;
    ifid_ld     = 1'b0;
    idex_ld     = 1'b0;
    exmem_ld    = 1'b0;
    memwb_ld    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    case (state)
      RUN: begin
        if (mem_halt) begin
          memwb_ld  = 1'b1;
          state_nxt = HALT;
        end else if (dreq && !dhit) begin
          memwb_flush = 1'b1;
          stall_ev    = 1'b1;
          state_nxt   = DWAIT;
        end else if (mem_pcSrc != 2'b00) begin
          pc_ld       = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          memwb_ld    = 1'b1;
          flush_ev    = 1'b1;
        end else if (lu_haz) begin
          idex_flush = 1'b1;
          exmem_ld   = 1'b1;
          memwb_ld   = 1'b1;
          stall_ev   = 1'b1;
        end else if (!ihit) begin
          ifid_flush = 1'b1;
          idex_ld    = 1'b1;
          exmem_ld   = 1'b1;
          memwb_ld   = 1'b1;
          stall_ev   = 1'b1;
        end else begin
          pc_ld    = 1'b1;
          ifid_ld  = 1'b1;
          idex_ld  = 1'b1;
          exmem_ld = 1'b1;
          memwb_ld = 1'b1;
        end
      end
      DWAIT: begin
        // Request vanished (flushed upstream): resume as a plain RUN cycle.
        if (!dreq) begin
          pc_ld     = 1'b1;
          ifid_ld   = 1'b1;
          idex_ld   = 1'b1;
          exmem_ld  = 1'b1;
          memwb_ld  = 1'b1;
          state_nxt = RUN;
        end else if (!dhit) begin
          memwb_flush = 1'b1;
          stall_ev    = 1'b1;
        end else begin
          pc_ld      = ihit;
          ifid_ld    = ihit;
          ifid_flush = !ihit;
          idex_ld    = 1'b1;
          exmem_ld   = 1'b1;
          memwb_ld   = 1'b1;
          state_nxt  = RUN;
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  // A latch that is flushed never also loads.
  assign pc_en    = pc_ld;
  assign ifid_en  = ifid_ld  & ~ifid_flush;
  assign idex_en  = idex_ld  & ~idex_flush;
  assign exmem_en = exmem_ld & ~exmem_flush;
  assign memwb_en = memwb_ld & ~memwb_flush;
  assign halt_o   = (state == HALT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != HALT) begin
      if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected latch controls are queued as
// stimulus is applied and compared mid-cycle; counters follow a bench-side model.
module tb_pipeline_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b1, dhit = 1'b0, mem_dREN = 1'b0, mem_dWEN = 1'b0;
  logic [1:0]  mem_pcSrc = 2'b00;
  logic        mem_halt = 1'b0, idex_dREN = 1'b0;
  logic [4:0]  idex_rd = 5'd0, ifid_rs1 = 5'd0, ifid_rs2 = 5'd0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_o;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_pcSrc(mem_pcSrc),
    .mem_halt(mem_halt), .idex_dREN(idex_dREN), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt_o(halt_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb flushes}
  logic [8:0] outs;
  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush};

  localparam logic [8:0] O_ALL    = 9'b11111_0000;
  localparam logic [8:0] O_DSTALL = 9'b00000_0001;
  localparam logic [8:0] O_REDIR  = 9'b10001_1110;
  localparam logic [8:0] O_LU     = 9'b00011_0100;
  localparam logic [8:0] O_NOIHIT = 9'b00111_1000;
  localparam logic [8:0] O_HALTC  = 9'b00001_0000;
  localparam logic [8:0] O_NONE   = 9'b00000_0000;

  logic [8:0] exp_q[$];
  logic [8:0] exp_v;
  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    mem_pcSrc = 2'b00; mem_halt = 1'b0; idex_dREN = 1'b0;
    idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
  endtask

  // Move to just after the next rising edge, where new inputs are applied.
  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1;
    checks++;
    if (halt_o !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_regs got halt=%b stall=%0d flush=%0d exp 0/0/0", halt_o, stall_cnt, flush_cnt);
    end
    exp_q.push_back(O_ALL);
    #1; exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, exp_v); end
    #1 nRST = 1'b1;
    next_cycle();
  endtask

  task automatic test_dwait();
    idle_inputs();
    mem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(O_DSTALL); exp_stall++;
      @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v) begin failures++; $display("FAIL dwait_stall%0d got=%b exp=%b", i, outs, exp_v); end
      next_cycle();
    end
    dhit = 1'b1; ihit = 1'b0;
    exp_q.push_back(O_NOIHIT);
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL dwait_done got=%b exp=%b", outs, exp_v); end
    next_cycle();
    idle_inputs();
    exp_q.push_back(O_ALL);
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL dwait_back_run got=%b exp=%b", outs, exp_v); end
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin
      failures++; $display("FAIL dwait_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_dwait_drop();
    idle_inputs();
    mem_dWEN = 1'b1; exp_stall++;
    next_cycle();
    mem_dWEN = 1'b0;
    exp_q.push_back(O_ALL);
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL dwait_drop got=%b exp=%b", outs, exp_v); end
    next_cycle();
    ihit = 1'b0;
    exp_q.push_back(O_NOIHIT); exp_stall++;
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL drop_in_run got=%b exp=%b", outs, exp_v); end
    next_cycle();
  endtask

  task automatic test_load_use();
    idle_inputs();
    idex_dREN = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5;
    exp_q.push_back(O_LU); exp_stall++;
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL lu_rs2 got=%b exp=%b", outs, exp_v); end
    next_cycle();
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin
      failures++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
    idex_rd = 5'd0; ifid_rs2 = 5'd0;
    exp_q.push_back(O_ALL);
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL lu_rd0 got=%b exp=%b", outs, exp_v); end
    next_cycle();
    idex_rd = 5'd17; ifid_rs1 = 5'd17; ifid_rs2 = 5'd3;
    exp_q.push_back(O_LU); exp_stall++;
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL lu_rs1 got=%b exp=%b", outs, exp_v); end
    next_cycle();
    idex_dREN = 1'b0;
    exp_q.push_back(O_ALL);
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL lu_not_load got=%b exp=%b", outs, exp_v); end
    next_cycle();
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin
      failures++; $display("FAIL lu_stall_cnt2 got=%0d exp=%0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_redirect();
    idle_inputs();
    mem_pcSrc = 2'b01; idex_dREN = 1'b1; idex_rd = 5'd9; ifid_rs1 = 5'd9; ihit = 1'b0;
    exp_q.push_back(O_REDIR); exp_flush++;
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL redirect_over_lu got=%b exp=%b", outs, exp_v); end
    next_cycle();
    idle_inputs();
    mem_pcSrc = 2'b10;
    exp_q.push_back(O_REDIR); exp_flush++;
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL redirect_plain got=%b exp=%b", outs, exp_v); end
    next_cycle();
    checks++;
    if (flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL redirect_cnts got flush=%0d stall=%0d exp flush=%0d stall=%0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
    end
  endtask

  task automatic test_dhit_same_cycle();
    idle_inputs();
    mem_dREN = 1'b1; dhit = 1'b1;
    exp_q.push_back(O_ALL);
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL dhit_now got=%b exp=%b", outs, exp_v); end
    next_cycle();
    mem_pcSrc = 2'b11;
    exp_q.push_back(O_REDIR); exp_flush++;
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL dhit_redirect got=%b exp=%b", outs, exp_v); end
    next_cycle();
    checks++;
    if (stall_cnt !== 16'(exp_stall) || flush_cnt !== 16'(exp_flush)) begin
      failures++;
      $display("FAIL dhit_cnts got stall=%0d flush=%0d exp stall=%0d flush=%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_reset_mid_dwait();
    idle_inputs();
    mem_dREN = 1'b1; exp_stall++;
    next_cycle();
    #2;
    nRST = 1'b0; mem_dREN = 1'b0; ihit = 1'b0;
    exp_stall = 0; exp_flush = 0;
    exp_q.push_back(O_NOIHIT);
    #1; exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL rst_mid_dwait_state got=%b exp=%b", outs, exp_v); end
    checks++;
    if (halt_o !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_mid_dwait_regs got halt=%b stall=%0d flush=%0d exp 0/0/0", halt_o, stall_cnt, flush_cnt);
    end
    @(negedge CLK); nRST = 1'b1;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_halt();
    idle_inputs();
    mem_halt = 1'b1;
    exp_q.push_back(O_HALTC);
    @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
    if (outs !== exp_v) begin failures++; $display("FAIL halt_cycle got=%b exp=%b", outs, exp_v); end
    checks++;
    if (halt_o !== 1'b0) begin failures++; $display("FAIL halt_early got=%b exp=0", halt_o); end
    next_cycle();
    mem_halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; dhit = ~i[0]; mem_dREN = i[1]; mem_pcSrc = i[2] ? 2'b01 : 2'b00;
      exp_q.push_back(O_NONE);
      @(negedge CLK); exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v || halt_o !== 1'b1) begin
        failures++; $display("FAIL halt_hold%0d got=%b halt=%b exp=%b halt=1", i, outs, halt_o, exp_v);
      end
      next_cycle();
    end
    checks++;
    if (stall_cnt !== 16'(exp_stall) || flush_cnt !== 16'(exp_flush)) begin
      failures++;
      $display("FAIL halt_frozen got stall=%0d flush=%0d exp stall=%0d flush=%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
    #2 nRST = 1'b0; exp_stall = 0; exp_flush = 0;
    #1; checks++;
    if (halt_o !== 1'b0) begin failures++; $display("FAIL halt_reset got=%b exp=0", halt_o); end
    @(negedge CLK); nRST = 1'b1;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_saturation();
    idle_inputs();
    idex_dREN = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd7;
    for (int i = 0; i < 65535; i++) begin
      if (exp_stall < 65535) exp_stall++;
      next_cycle();
    end
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin
      failures++; $display("FAIL sat_reach got=%0d exp=%0d", stall_cnt, exp_stall);
    end
    if (exp_stall < 65535) exp_stall++;
    next_cycle();
    checks++;
    if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'd0) begin
      failures++; $display("FAIL sat_hold got stall=%0h flush=%0d exp stall=ffff flush=0", stall_cnt, flush_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_dwait();
    test_dwait_drop();
    test_load_use();
    test_redirect();
    test_dhit_same_cycle();
    test_reset_mid_dwait();
    test_halt();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Each cycle it decides whether each latch loads, holds or flushes. Inputs are cache hit status, the memory-stage access, resolved control flow, load-use hazards and halt.
- A small FSM tracks outstanding data-memory accesses and a sticky halt. Saturating counters report stall and flush events.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt performance counters

Ports:
CLK  in  1  system clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch completed this cycle
dhit  in  1  data access completed this cycle
mem_dREN  in  1  memory-stage load request (EX/MEM latch output)
mem_dWEN  in  1  memory-stage store request (EX/MEM latch output)
mem_pcSrc  in  2  memory-stage PC source; nonzero = taken branch/jump redirect
mem_halt  in  1  halt instruction in memory stage
idex_dREN  in  1  load in execute stage
idex_rd  in  5  destination of execute-stage instruction
ifid_rs1  in  5  source 1 of decode-stage instruction
ifid_rs2  in  5  source 2 of decode-stage instruction
pc_en  out  1  PC update enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch load enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flush (flush dominates enable)
halt_o  out  1  sticky processor halted
stall_cnt  out  CNT_W  stall cycles seen
flush_cnt  out  CNT_W  redirect flushes seen

Behaviour:
- One clock, CLK. Reset is asynchronous and active-low on nRST.
- Reset: state=RUN, halt_o=0, stall_cnt=0, flush_cnt=0. Reset mid-stall or mid-halt returns to RUN immediately.
- States: RUN, DWAIT, HALT. Enable and flush outputs are combinational from state and current inputs, giving zero-cycle latency. State and counters are registered.
- dreq = mem_dREN | mem_dWEN.
- lu_haz = idex_dREN & (idex_rd != 0) & (idex_rd == ifid_rs1 | idex_rd == ifid_rs2).
- RUN outputs use first matching priority. Outputs not listed are 0.
  1. mem_halt: memwb_en=1 only. Next state HALT.
  2. dreq & !dhit: memwb_flush=1, all other enables 0. Next state DWAIT. Stall event.
  3. mem_pcSrc != 0: pc_en=1, ifid_flush=1, idex_flush=1, exmem_flush=1, memwb_en=1. Flush event.
  4. lu_haz: ifid_en=0, pc_en=0, idex_flush=1, exmem_en=1, memwb_en=1. Stall event.
  5. !ihit: pc_en=0, ifid_flush=1, idex_en=1, exmem_en=1, memwb_en=1. Stall event.
  6. Otherwise: all enables 1.
- Rule 2 when dhit=1 is not a stall. That cycle follows rules 3–6.
- DWAIT:
  - dhit=0: same outputs as rule 2, remain in DWAIT, stall event. mem_pcSrc and mem_halt are ignored.
  - dhit=1: memwb_en=1, exmem_en=1, idex_en=1. pc_en=ihit and ifid_en=ihit; ifid_flush=!ihit. Next state RUN. No stall event.
  - dreq dropping to 0 while in DWAIT (flushed upstream) returns to RUN with rule-6 outputs.
- HALT: all enables and flushes 0, halt_o=1. Exit only by reset. halt_o rises the cycle after RUN rule 1 fires.
- Counters: each stall event adds 1 to stall_cnt; each flush event adds 1 to flush_cnt. Both saturate at 2^CNT_W-1, with no wrap. They freeze in HALT.
- Flush and enable asserted together on one latch: flush wins.

Test Plan:
- Reset with nRST=0 mid-DWAIT → next observable state RUN, halt_o=0, stall_cnt=0, flush_cnt=0, no wait for CLK.
- mem_dREN=1 with dhit=0 for 3 cycles, then 1 → 3 cycles of all enables 0 and memwb_flush=1. Fourth cycle exmem_en=memwb_en=1, then return to RUN. stall_cnt=3.
- idex_dREN=1, idex_rd=5, ifid_rs2=5, ihit=1 → pc_en=0, ifid_en=0, idex_flush=1, stall_cnt+1. Repeat with idex_rd=0 → no stall.
- mem_pcSrc=2'b01 with lu_haz=1 and ihit=0 → redirect wins: ifid/idex/exmem_flush=1, pc_en=1, flush_cnt+1, stall_cnt unchanged.
- Preload stall_cnt to 0xFFFF via 65535 stall cycles, then one more → stall_cnt stays 0xFFFF.
- mem_halt=1 in RUN → that cycle memwb_en=1 only. Next cycle halt_o=1 and all enables 0, held for 10 cycles despite ihit/dhit toggling, until nRST=0.
